// File: rtl/sym_frame_tx.sv
// rtl/sym_frame_tx.sv - serialises a payload word into a 2-bit symbol frame (header, payload, idle gap)
// Frame: 01,10,11 header, payload MSB-first two bits per cycle, then GAP_CYCLES idle 00 symbols.
module sym_frame_tx #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              abort,
  output logic [1:0]        num,
  output logic              busy,
  output logic              done
);

  localparam int HALF  = DATA_W / 2;
  localparam int CNT_W = $clog2(HALF) + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(HALF - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, HDR, DATA, GAP} state_t;

  state_t            state, state_nxt;
  logic [1:0]        hdr_idx, hdr_idx_nxt;
  logic [CNT_W-1:0]  sym_cnt, sym_cnt_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
  logic [DATA_W-1:0] sreg, sreg_nxt;
  logic [1:0]        num_nxt;
  logic              busy_nxt;
  logic              done_nxt;

  assign in_ready = (state == IDLE) && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      hdr_idx <= '0;
      sym_cnt <= '0;
      gap_cnt <= '0;
      sreg    <= '0;
      num     <= 2'b00;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      hdr_idx <= hdr_idx_nxt;
      sym_cnt <= sym_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
      sreg    <= sreg_nxt;
      num     <= num_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  // Outputs are computed one cycle ahead so num/busy/done come straight from flops.
  always_comb begin
    state_nxt   = state;
    hdr_idx_nxt = hdr_idx;
    sym_cnt_nxt = sym_cnt;
    gap_cnt_nxt = gap_cnt;
    sreg_nxt    = sreg;
    num_nxt     = num;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        num_nxt  = 2'b00;
        busy_nxt = 1'b0;
        if (in_valid && in_ready) begin
          state_nxt   = HDR;
          num_nxt     = 2'b01;
          busy_nxt    = 1'b1;
          hdr_idx_nxt = 2'd1;
          sreg_nxt    = in_data;
          sym_cnt_nxt = '0;
          gap_cnt_nxt = '0;
        end
      end
      HDR: begin
        if (hdr_idx == 2'd3) begin
          state_nxt   = DATA;
          hdr_idx_nxt = 2'd0;
          num_nxt     = sreg[DATA_W-1 -: 2];
          sreg_nxt    = sreg << 2;
          sym_cnt_nxt = CNT_W'(1);
          done_nxt    = (HALF == 1);
        end else begin
          hdr_idx_nxt = hdr_idx + 2'd1;
          num_nxt     = hdr_idx + 2'd1;
        end
      end
      DATA: begin
        if (sym_cnt == CNT_LAST) begin
          state_nxt   = GAP;
          num_nxt     = 2'b00;
          sreg_nxt    = '0;
          sym_cnt_nxt = '0;
          gap_cnt_nxt = GAP_W'(1);
        end else begin
          num_nxt     = sreg[DATA_W-1 -: 2];
          sreg_nxt    = sreg << 2;
          sym_cnt_nxt = sym_cnt + CNT_W'(1);
          done_nxt    = (sym_cnt == CNT_PEN);
        end
      end
      GAP: begin
        num_nxt = 2'b00;
        if (gap_cnt == GAP_LAST) begin
          state_nxt   = IDLE;
          busy_nxt    = 1'b0;
          gap_cnt_nxt = '0;
        end else begin
          gap_cnt_nxt = gap_cnt + GAP_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        num_nxt   = 2'b00;
        busy_nxt  = 1'b0;
      end
    endcase
    // Abort wins over every in-frame transition and drops the latched payload.
    if (abort && (state != IDLE)) begin
      state_nxt   = IDLE;
      hdr_idx_nxt = '0;
      sym_cnt_nxt = '0;
      gap_cnt_nxt = '0;
      sreg_nxt    = '0;
      num_nxt     = 2'b00;
      busy_nxt    = 1'b0;
      done_nxt    = 1'b0;
    end
  end

endmodule

// File: tb/tb_sym_frame_tx.sv
// tb/tb_sym_frame_tx.sv - randomized self-checking bench for sym_frame_tx
// The reference is a queue of expected {num, busy, done} cycles built per accepted word.
module tb_sym_frame_tx;

  localparam int DATA_W = 8;
  localparam int GAP    = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              abort;
  logic [1:0]        num;
  logic              busy;
  logic              done;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_q[$];

  sym_frame_tx #(.DATA_W(DATA_W), .GAP_CYCLES(GAP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .abort    (abort),
    .num      (num),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] cur_exp();
    return (exp_q.size() != 0) ? exp_q[0] : 4'b0000;
  endfunction

  task automatic push_frame(input logic [DATA_W-1:0] word);
    for (int h = 1; h <= 3; h++) exp_q.push_back({2'(h), 1'b1, 1'b0});
    for (int i = 0; i < DATA_W / 2; i++)
      exp_q.push_back({2'((word >> (DATA_W - 2 - 2 * i)) & 3), 1'b1, 1'(i == DATA_W / 2 - 1)});
    for (int g = 0; g < GAP; g++) exp_q.push_back(4'b0010);
  endtask

  // Compare mid-cycle, then advance the model on the rising edge with the inputs in force.
  task automatic tick();
    logic [3:0] e;
    @(negedge clk);
    e = cur_exp();
    check("num", num, e[3:2]);
    check("busy", busy, e[1]);
    check("done", done, e[0]);
    check("in_ready", in_ready, (exp_q.size() == 0) && !abort);
    @(posedge clk);
    if (rst_n) begin
      if (exp_q.size() != 0) begin
        if (abort) exp_q.delete();
        else void'(exp_q.pop_front());
      end else if (in_valid && !abort) begin
        push_frame(in_data);
      end
    end
    #1;
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_num", num, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    abort    = 1'b0;
    #12;
    check("rst_num", num, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    #4 rst_n = 1'b1;
    #1;
    check("rst_ready", in_ready, 1);

    in_valid = 1'b1; in_data = 8'hB4;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      in_data = 8'($urandom);
      tick();
    end

    in_valid = 1'b1; in_data = 8'hFF;
    tick();
    in_data = 8'h1B;
    for (int i = 0; i < 9; i++) tick();
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();

    in_valid = 1'b1; in_data = 8'hB4;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    in_valid = 1'b1; in_data = 8'h00;
    tick();
    in_valid = 1'b0;
    tick();
    check("hdr_mid", num, 2'b10);
    async_reset();
    in_valid = 1'b1; in_data = 8'h00;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    for (int i = 0; i < 20; i++) tick();
    abort = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    abort = 1'b0; in_valid = 1'b0;
    tick();

    for (int i = 0; i < 800; i++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      abort    = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0) async_reset();
      tick();
    end
    abort = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
